combo_lock_param: RTL

- Parametrised successor to the two-digit combination lock.
- Accepts an N-digit code of configurable digit width, one digit per Enter cycle, and opens only if every digit matched.
- Mismatches are not revealed until the full sequence is entered.
- Adds a failure counter with timed lockout and in-field reprogramming of the code while open.
- Sits between the keypad/debounce front end and the door-actuator/status LEDs.

---
 rtl/combo_lock_param.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/combo_lock_param.sv
// rtl/combo_lock_param.sv - N-digit combination lock with fail lockout and in-field reprogramming
// The verdict is held back until the last digit so a wrong digit cannot be located by timing.
module combo_lock_param #(
  parameter int DIGIT_WIDTH = 4,
  parameter int NUM_DIGITS = 4,
  parameter logic [NUM_DIGITS*DIGIT_WIDTH-1:0] DEFAULT_CODE = 16'h2323,
  parameter int MAX_FAILS = 3,
  parameter int LOCKOUT_CYCLES = 1024,
  localparam int CW = $clog2(NUM_DIGITS + 1),
  localparam int FW = $clog2(MAX_FAILS + 1)
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Enter,
  input  logic [DIGIT_WIDTH-1:0] Digit,
  input  logic                   Relock,
  input  logic                   Program,
  output logic [2:0]             State,
  output logic                   Open,
  output logic                   Fail,
  output logic                   Lockout,
  output logic [CW-1:0]          DigitCount,
  output logic [FW-1:0]          FailCount
);

  localparam int CODE_W = NUM_DIGITS * DIGIT_WIDTH;
  localparam int TW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [2:0] S_LOCKED  = 3'b000;
  localparam logic [2:0] S_ENTRY   = 3'b001;
  localparam logic [2:0] S_OPEN    = 3'b010;
  localparam logic [2:0] S_FAIL    = 3'b011;
  localparam logic [2:0] S_LOCKOUT = 3'b100;
  localparam logic [2:0] S_PROGRAM = 3'b101;

  logic [2:0]             state_q, state_d;
  logic [CODE_W-1:0]      code_q, code_d, shadow_q, shadow_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [FW-1:0]          fails_q, fails_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   mismatch_q, mismatch_d;

  logic [DIGIT_WIDTH-1:0] expected_digit;
  logic [CODE_W-1:0]      shadow_wr;
  logic                   first_miss, entry_miss, res_miss, last_digit;
  logic [2:0]             res_state;
  logic [FW-1:0]          res_fails;
  logic [TW-1:0]          res_timer;

  // Digit 0 lives in the most significant slot of the code word.
  always_comb begin
    expected_digit = code_q[CODE_W-1 -: DIGIT_WIDTH];
    shadow_wr      = shadow_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cnt_q == CW'(i)) begin
        expected_digit = code_q[(NUM_DIGITS-1-i)*DIGIT_WIDTH +: DIGIT_WIDTH];
        shadow_wr[(NUM_DIGITS-1-i)*DIGIT_WIDTH +: DIGIT_WIDTH] = Digit;
      end
    end
  end

  assign first_miss = (Digit != code_q[CODE_W-1 -: DIGIT_WIDTH]);
  assign entry_miss = mismatch_q | (Digit != expected_digit);
  assign res_miss   = (state_q == S_ENTRY) ? entry_miss : first_miss;
  assign last_digit = (cnt_q == CW'(NUM_DIGITS - 1));

  always_comb begin
    res_state = S_OPEN;
    res_fails = '0;
    res_timer = '0;
    if (res_miss) begin
      if (int'(fails_q) + 1 < MAX_FAILS) begin
        res_state = S_FAIL;
        res_fails = fails_q + FW'(1);
      end else begin
        res_state = S_LOCKOUT;
        res_fails = FW'(MAX_FAILS);
        res_timer = TW'(LOCKOUT_CYCLES - 1);
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_LOCKED;
      code_q     <= DEFAULT_CODE;
      shadow_q   <= DEFAULT_CODE;
      cnt_q      <= '0;
      fails_q    <= '0;
      timer_q    <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      shadow_q   <= shadow_d;
      cnt_q      <= cnt_d;
      fails_q    <= fails_d;
      timer_q    <= timer_d;
      mismatch_q <= mismatch_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    shadow_d   = shadow_q;
    cnt_d      = cnt_q;
    fails_d    = fails_q;
    timer_d    = timer_q;
    mismatch_d = mismatch_q;
    case (state_q)
      S_LOCKED, S_FAIL: begin
        if (Relock) begin
          state_d = S_LOCKED;
        end else if (Enter) begin
          if (NUM_DIGITS == 1) begin
            state_d    = res_state;
            fails_d    = res_fails;
            timer_d    = res_timer;
            cnt_d      = '0;
            mismatch_d = 1'b0;
          end else begin
            state_d    = S_ENTRY;
            cnt_d      = CW'(1);
            mismatch_d = first_miss;
          end
        end
      end
      S_ENTRY: begin
        if (Relock) begin
          state_d    = S_LOCKED;
          cnt_d      = '0;
          mismatch_d = 1'b0;
        end else if (Enter) begin
          if (last_digit) begin
            state_d    = res_state;
            fails_d    = res_fails;
            timer_d    = res_timer;
            cnt_d      = '0;
            mismatch_d = 1'b0;
          end else begin
            cnt_d      = cnt_q + CW'(1);
            mismatch_d = entry_miss;
          end
        end
      end
      S_OPEN: begin
        if (Relock) begin
          state_d = S_LOCKED;
        end else if (Program) begin
          state_d = S_PROGRAM;
          cnt_d   = '0;
        end
      end
      S_PROGRAM: begin
        if (Relock) begin
          state_d = S_LOCKED;
          cnt_d   = '0;
        end else if (Enter) begin
          if (last_digit) begin
            code_d  = shadow_wr;
            state_d = S_LOCKED;
            cnt_d   = '0;
          end else begin
            shadow_d = shadow_wr;
            cnt_d    = cnt_q + CW'(1);
          end
        end
      end
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = S_LOCKED;
          fails_d = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d    = S_LOCKED;
        cnt_d      = '0;
        mismatch_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    Open    = (state_q == S_OPEN) || (state_q == S_PROGRAM);
    Fail    = (state_q == S_FAIL) || (state_q == S_LOCKOUT);
    Lockout = (state_q == S_LOCKOUT);
  end

  assign State      = state_q;
  assign DigitCount = cnt_q;
  assign FailCount  = fails_q;

endmodule
